data_writer: RTL and testbench
==============================

// Module: data_writer
// PURPOSE
//  Write-side counterpart of the counter-driven BRAM reader. Accepts a stream of
//  DWIDTH words over a valid/ready handshake. Writes them to consecutive addresses
//  0..N-1 of a true_dpbram port, where N is latched from cnt_val_i on start.
//  Exposes idle/run/done status matching the reader, so a top level can fill a
//  buffer and then read it back.
// PARAMETERS
//  DWIDTH     32   data word width
//  CNT_WIDTH  7    address/count width; drives BRAM AWIDTH
//  MEM_SIZE   100  BRAM depth in words; upper clamp for the transfer count
// PORTS
//  clk         in   1          clock, rising edge
//  rst         in   1          synchronous reset, active-high
//  start_i     in   1          start a transfer; sampled only in IDLE
//  cnt_val_i   in   CNT_WIDTH  number of words to write; sampled with start_i
//  s_valid_i   in   1          input word valid
//  s_data_i    in   DWIDTH     input word
//  s_ready_o   out  1          block accepts a word this cycle
//  addr_o      out  CNT_WIDTH  BRAM address
//  ce_o        out  1          BRAM chip enable
//  we_o        out  1          BRAM write enable
//  d_o         out  DWIDTH     BRAM write data
//  idle_o      out  1          state == IDLE
//  run_o       out  1          state == RUN
//  done_o      out  1          state == DONE; one-cycle pulse
// BEHAVIOUR
//  - FSM states: IDLE -> RUN -> DONE -> IDLE. Outputs idle_o/run_o/done_o decode
//    the state register.
//  - Reset state: IDLE. At reset, idle_o=1; every other output is 0;
//    the internal counters are 0.
//  - IDLE: if start_i=1, latch N=min(cnt_val_i, MEM_SIZE) and clear wr_cnt.
//    Next state is RUN, or DONE if N==0 (no writes issued).
//  - start_i is ignored outside IDLE. cnt_val_i is don't-care outside the start cycle.
//  - RUN: s_ready_o=1 combinationally. A handshake is s_valid_i & s_ready_o.
//  - On a handshake in cycle t: in cycle t+1, ce_o=we_o=1, addr_o=wr_cnt(t),
//    d_o=s_data_i(t). wr_cnt increments.
//  - Write port is registered, with 1-cycle latency. ce_o/we_o are high for exactly one
//    cycle per accepted word. Otherwise ce_o=we_o=0, and addr_o/d_o hold their values.
//  - Back-to-back handshakes give one write per cycle. Bubbles in s_valid_i
//    stall with no write.
//  - On the handshake where wr_cnt==N-1, next state is DONE. The last write appears
//    on the port in the same cycle that done_o=1.
//  - DONE lasts exactly one cycle, with s_ready_o=0; next state is IDLE. A start_i
//    during DONE is dropped.
//  - Addresses never wrap. Max address is N-1 <= MEM_SIZE-1. wr_cnt is CNT_WIDTH
//    bits wide, and MEM_SIZE <= 2**CNT_WIDTH is required.
//  - rst asserted mid-RUN aborts the transfer. In the next cycle state is IDLE,
//    s_ready_o=0 and ce_o=we_o=0. A write pending in the port register is squashed.
// CONFIGURATION
//  - Macro DATA_WRITER_CHECKSUM_EN.
//  - Defined: adds output checksum_o[DWIDTH-1:0]. It is cleared on an accepted
//    start_i and reset, and adds d_o modulo 2**DWIDTH in every cycle where we_o=1.
//    It is valid when done_o=1, and holds until the next start.
//  - Undefined: checksum_o port and adder are absent. All other behaviour is
//    identical.
// TESTING
//  1. Reset: hold rst for 2 cycles -> idle_o=1; run_o, done_o, s_ready_o, ce_o
//     and we_o all 0.
//  2. start_i with cnt_val_i=4, data 0x10..0x13 streamed with valid held high ->
//     writes to addr 0..3 in 4 consecutive cycles; done_o pulses in the
//     same cycle as the addr-3 write; idle_o=1 on the next cycle.
//  3. Same as test 2, with s_valid_i low for 2 cycles after word 1 -> no ce_o during the
//     bubble; addresses stay contiguous 0..3; done_o is delayed by 2 cycles.
//  4. cnt_val_i=0 -> RUN is never entered, done_o pulses 1 cycle after start, no
//     writes. Then cnt_val_i=120 -> exactly 100 writes, addr 0..99.
//  5. Reset after 2 of 4 words -> the third write never appears; idle_o=1. A new
//     start with cnt_val_i=2 writes starting at addr 0.
//  6. With DATA_WRITER_CHECKSUM_EN defined, write 1,2,3,0xFFFFFFFF -> checksum_o=5
//     at done_o. start_i pulsed mid-RUN -> ignored, and the count is unchanged.

Source files
------------

// File: rtl/data_writer.sv
// Stream-to-BRAM writer: accepts N words over valid/ready and writes them to addresses 0..N-1.
// Optional macro DATA_WRITER_CHECKSUM_EN adds a running checksum_o of the written words.
module data_writer #(
  parameter int DWIDTH    = 32,
  parameter int CNT_WIDTH = 7,
  parameter int MEM_SIZE  = 100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [CNT_WIDTH-1:0] cnt_val_i,
  input  logic                 s_valid_i,
  input  logic [DWIDTH-1:0]    s_data_i,
  output logic                 s_ready_o,
  output logic [CNT_WIDTH-1:0] addr_o,
  output logic                 ce_o,
  output logic                 we_o,
  output logic [DWIDTH-1:0]    d_o,
  output logic                 idle_o,
  output logic                 run_o,
  output logic                 done_o
`ifdef DATA_WRITER_CHECKSUM_EN
  ,
  output logic [DWIDTH-1:0]    checksum_o
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One extra bit so MEM_SIZE == 2**CNT_WIDTH still compares correctly.
  localparam logic [CNT_WIDTH:0] MEM_SIZE_W = (CNT_WIDTH+1)'(MEM_SIZE);

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] n_q, n_d;
  logic [CNT_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic                 ce_q, ce_d;
  logic [CNT_WIDTH-1:0] addr_q, addr_d;
  logic [DWIDTH-1:0]    d_q, d_d;

  logic [CNT_WIDTH-1:0] n_start;
  logic                 hs;
  logic                 last_word;
  logic                 start_acc;

  assign n_start   = ({1'b0, cnt_val_i} > MEM_SIZE_W) ? MEM_SIZE_W[CNT_WIDTH-1:0] : cnt_val_i;
  assign s_ready_o = (state_q == RUN);
  assign hs        = s_valid_i & s_ready_o;
  assign last_word = (wr_cnt_q == n_q - CNT_WIDTH'(1));
  assign start_acc = (state_q == IDLE) & start_i;

  always_comb begin
    state_d  = state_q;
    n_d      = n_q;
    wr_cnt_d = wr_cnt_q;
    ce_d     = 1'b0;
    addr_d   = addr_q;
    d_d      = d_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          n_d      = n_start;
          wr_cnt_d = '0;
          state_d  = (n_start == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (hs) begin
          ce_d     = 1'b1;
          addr_d   = wr_cnt_q;
          d_d      = s_data_i;
          wr_cnt_d = wr_cnt_q + CNT_WIDTH'(1);
          if (last_word) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      n_q      <= '0;
      wr_cnt_q <= '0;
      ce_q     <= 1'b0;
      addr_q   <= '0;
      d_q      <= '0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      wr_cnt_q <= wr_cnt_d;
      ce_q     <= ce_d;
      addr_q   <= addr_d;
      d_q      <= d_d;
    end
  end

  assign ce_o   = ce_q;
  assign we_o   = ce_q;
  assign addr_o = addr_q;
  assign d_o    = d_q;
  assign idle_o = (state_q == IDLE);
  assign run_o  = (state_q == RUN);
  assign done_o = (state_q == DONE);

`ifdef DATA_WRITER_CHECKSUM_EN
  logic [DWIDTH-1:0] cks_q, cks_d;

  // Summed at the handshake so the total already includes the word on the port.
  always_comb begin
    cks_d = cks_q;
    if (start_acc)
      cks_d = '0;
    else if (hs)
      cks_d = cks_q + s_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) cks_q <= '0;
    else     cks_q <= cks_d;
  end

  assign checksum_o = cks_q;
`else
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_data_writer.sv
// Directed bench for data_writer: a cycle table for the basic and bubbled transfers,
// plus hand-written sequences for zero/clamped counts, mid-run reset and checksum.
module tb_data_writer;

  localparam int DW = 32;
  localparam int CW = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_i;
  logic [CW-1:0] cnt_val_i;
  logic          s_valid_i;
  logic [DW-1:0] s_data_i;
  logic          s_ready_o;
  logic [CW-1:0] addr_o;
  logic          ce_o;
  logic          we_o;
  logic [DW-1:0] d_o;
  logic          idle_o;
  logic          run_o;
  logic          done_o;
`ifdef DATA_WRITER_CHECKSUM_EN
  logic [DW-1:0] checksum_o;
`endif

  data_writer #(.DWIDTH(DW), .CNT_WIDTH(CW), .MEM_SIZE(100)) dut (
    .clk       (clk),
    .rst       (rst),
    .start_i   (start_i),
    .cnt_val_i (cnt_val_i),
    .s_valid_i (s_valid_i),
    .s_data_i  (s_data_i),
    .s_ready_o (s_ready_o),
    .addr_o    (addr_o),
    .ce_o      (ce_o),
    .we_o      (we_o),
    .d_o       (d_o),
    .idle_o    (idle_o),
    .run_o     (run_o),
    .done_o    (done_o)
`ifdef DATA_WRITER_CHECKSUM_EN
    ,
    .checksum_o(checksum_o)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic          start;
    logic [CW-1:0] cnt;
    logic          valid;
    logic [DW-1:0] data;
    logic          ready;
    logic          ce;
    logic          idle;
    logic          run;
    logic          done;
    logic [CW-1:0] addr;
    logic [DW-1:0] d;
  } vec_t;

  function automatic vec_t mk(logic st, logic [CW-1:0] c, logic v, logic [DW-1:0] dat,
                              logic rdy, logic ce, logic idl, logic rn, logic dn,
                              logic [CW-1:0] a, logic [DW-1:0] dd);
    vec_t r;
    r.start = st; r.cnt = c; r.valid = v; r.data = dat;
    r.ready = rdy; r.ce = ce; r.idle = idl; r.run = rn; r.done = dn;
    r.addr = a; r.d = dd;
    return r;
  endfunction

  vec_t          vt [16];
  logic [DW-1:0] wdat [128];

  // Streams words from wdat with valid held high; checks every write and when done_o lands.
  task automatic stream(input int cnt, input int expw, input int mid_start, input string tag);
    int hs = 0;
    int nwr = 0;
    int done_it = -1;
    start_i   = 1'b1;
    cnt_val_i = CW'(cnt);
    s_valid_i = 1'b0;
    for (int it = 0; it < 300; it++) begin
      @(negedge clk);
      start_i   = (it == mid_start);
      cnt_val_i = 7'd2;
      s_valid_i = 1'b1;
      s_data_i  = wdat[hs];
      #1;
      if (ce_o) begin
        chk($sformatf("%s addr w%0d", tag, nwr), 32'(addr_o), 32'(nwr));
        chk($sformatf("%s data w%0d", tag, nwr), d_o, wdat[nwr]);
        nwr++;
      end
      if (s_ready_o) hs++;
      if (done_o) begin
        done_it = it;
`ifdef DATA_WRITER_CHECKSUM_EN
        begin
          logic [DW-1:0] sum = '0;
          for (int k = 0; k < expw; k++) sum += wdat[k];
          chk($sformatf("%s checksum", tag), checksum_o, sum);
        end
`endif
        break;
      end
    end
    chk($sformatf("%s done cycle", tag), done_it, expw);
    chk($sformatf("%s write count", tag), nwr, expw);
    @(negedge clk);
    start_i   = 1'b0;
    s_valid_i = 1'b0;
    #1;
    chk($sformatf("%s idle after", tag), {idle_o, ce_o, s_ready_o}, 3'b100);
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; cnt_val_i = '0; s_valid_i = 1'b0; s_data_i = '0;

    //            st cnt  v  data    rdy ce idl run dn addr d
    vt[0]  = mk(1, 7'd4, 0, 32'h00, 0, 0, 1, 0, 0, 7'd0, 32'h00);
    vt[1]  = mk(0, 7'd0, 1, 32'h10, 1, 0, 0, 1, 0, 7'd0, 32'h00);
    vt[2]  = mk(0, 7'd0, 1, 32'h11, 1, 1, 0, 1, 0, 7'd0, 32'h10);
    vt[3]  = mk(0, 7'd0, 1, 32'h12, 1, 1, 0, 1, 0, 7'd1, 32'h11);
    vt[4]  = mk(0, 7'd0, 1, 32'h13, 1, 1, 0, 1, 0, 7'd2, 32'h12);
    vt[5]  = mk(0, 7'd0, 0, 32'h00, 0, 1, 0, 0, 1, 7'd3, 32'h13);
    vt[6]  = mk(0, 7'd0, 0, 32'h00, 0, 0, 1, 0, 0, 7'd3, 32'h13);
    vt[7]  = mk(1, 7'd4, 0, 32'h00, 0, 0, 1, 0, 0, 7'd3, 32'h13);
    vt[8]  = mk(0, 7'd0, 1, 32'h20, 1, 0, 0, 1, 0, 7'd3, 32'h13);
    vt[9]  = mk(0, 7'd0, 1, 32'h21, 1, 1, 0, 1, 0, 7'd0, 32'h20);
    vt[10] = mk(0, 7'd0, 0, 32'h00, 1, 1, 0, 1, 0, 7'd1, 32'h21);
    vt[11] = mk(0, 7'd0, 0, 32'h00, 1, 0, 0, 1, 0, 7'd1, 32'h21);
    vt[12] = mk(0, 7'd0, 1, 32'h22, 1, 0, 0, 1, 0, 7'd1, 32'h21);
    vt[13] = mk(0, 7'd0, 1, 32'h23, 1, 1, 0, 1, 0, 7'd2, 32'h22);
    vt[14] = mk(1, 7'd4, 0, 32'h00, 0, 1, 0, 0, 1, 7'd3, 32'h23);
    vt[15] = mk(0, 7'd0, 0, 32'h00, 0, 0, 1, 0, 0, 7'd3, 32'h23);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset status", {idle_o, run_o, done_o, s_ready_o, ce_o, we_o}, 6'b100000);
    chk("reset addr", 32'(addr_o), 32'd0);
    chk("reset data", d_o, 32'd0);

    // Basic and bubbled 4-word transfers; row 14 also drops a start during DONE.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      start_i = vt[i].start; cnt_val_i = vt[i].cnt;
      s_valid_i = vt[i].valid; s_data_i = vt[i].data;
      #1;
      chk($sformatf("row%0d ready", i), 32'(s_ready_o), 32'(vt[i].ready));
      chk($sformatf("row%0d ce/we", i), {30'd0, ce_o, we_o}, {30'd0, vt[i].ce, vt[i].ce});
      chk($sformatf("row%0d status", i), {29'd0, idle_o, run_o, done_o},
          {29'd0, vt[i].idle, vt[i].run, vt[i].done});
      chk($sformatf("row%0d addr", i), 32'(addr_o), 32'(vt[i].addr));
      chk($sformatf("row%0d data", i), d_o, vt[i].d);
    end

    // Zero count: straight to DONE, no writes.
    for (int k = 0; k < 128; k++) wdat[k] = 32'h100 + 32'(k);
    @(negedge clk);
    stream(0, 0, -1, "cnt0");
    // Count above depth clamps to 100 writes.
    stream(120, 100, -1, "cnt120");

    // Reset after two accepted words squashes the pending write.
    start_i = 1'b1; cnt_val_i = 7'd4;
    @(negedge clk); start_i = 1'b0; s_valid_i = 1'b1; s_data_i = 32'h30;
    @(negedge clk); s_data_i = 32'h31;
    @(negedge clk); s_data_i = 32'h32; rst = 1'b1;
    #1;
    chk("pre-reset write addr", 32'(addr_o), 32'd1);
    @(negedge clk); rst = 1'b0; s_valid_i = 1'b0;
    #1;
    chk("post-reset status", {idle_o, run_o, s_ready_o, ce_o, we_o}, 5'b10000);
    @(negedge clk);
    #1;
    chk("post-reset no write", {ce_o, we_o}, 2'b00);
    stream(2, 2, -1, "restart");

    // Checksum wrap and a start pulsed mid-run that must be ignored.
    wdat[0] = 32'd1; wdat[1] = 32'd2; wdat[2] = 32'd3; wdat[3] = 32'hFFFF_FFFF;
    stream(4, 4, 1, "midstart");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
